// File: rtl/cmpt_pkg.sv
// Shared encodings, field positions and default latencies for the compute issue path.
package cmpt_pkg;

  localparam int WORD_W = 21;
  localparam int NREG   = 16;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'b00,
    UNIT_MUL = 2'b01,
    UNIT_SHF = 2'b10,
    UNIT_ILL = 2'b11
  } unit_e;

  // Field positions inside the 21-bit compute field (instruction bits 25:5)
  localparam int UNIT_HI = 20, UNIT_LO = 19;
  localparam int MSRC_HI = 18, MSRC_LO = 17;
  localparam int MRF_BIT = 16;
  localparam int CMP_BIT = 14;
  localparam int DST_HI  = 11, DST_LO  = 8;
  localparam int SRCA_HI = 7,  SRCA_LO = 4;
  localparam int SRCB_HI = 3,  SRCB_LO = 0;

  // One-hot unit strobes, ordered {SHF,MUL,ALU}
  localparam logic [2:0] OH_ALU = 3'b001;
  localparam logic [2:0] OH_MUL = 3'b010;
  localparam logic [2:0] OH_SHF = 3'b100;

  localparam int ALU_LAT_D = 1;
  localparam int MUL_LAT_D = 3;
  localparam int SHF_LAT_D = 2;
  localparam int MAX_LAT_D = 4;

  typedef struct packed {
    logic       vld;
    logic [2:0] unit;
    logic [3:0] addr;
  } wb_ent_t;

  typedef struct packed {
    logic       ill;
    logic [2:0] oh;
    logic       wr;
    logic       use_a;
    logic       use_b;
    logic [3:0] dst;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } dec_t;

endpackage

// File: rtl/cmpt_wb_slots.sv
// Write-port reservation shift register; ent[k] retires k+1 cycles from now,
// the retiring entry is held in a register that drives the write-back strobe.
module cmpt_wb_slots
  import cmpt_pkg::*;
#(
  parameter int MAX_LAT = MAX_LAT_D,
  parameter int LW      = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             rsv,
  input  logic [LW-1:0]    rsv_pos,
  input  wb_ent_t          rsv_ent,
  output logic [MAX_LAT:0] occ,
  output wb_ent_t          ret
);

  wb_ent_t [MAX_LAT:0] ent;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ent <= '0;
      ret <= '0;
    end else begin
      ret <= ent[0];
      for (int k = 0; k < MAX_LAT; k++) ent[k] <= ent[k+1];
      ent[MAX_LAT] <= '0;
      if (rsv) ent[rsv_pos] <= rsv_ent;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k <= MAX_LAT; k++) occ[k] = ent[k].vld;
  end

endmodule

// File: rtl/cmpt_issue_sched.sv
// Compute issue scheduler: scoreboard hazard check, write-port slot reservation,
// one-cycle registered issue pulse to the compute decoder.
module cmpt_issue_sched
  import cmpt_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_D,
  parameter int MUL_LAT = MUL_LAT_D,
  parameter int SHF_LAT = SHF_LAT_D,
  parameter int MAX_LAT = MAX_LAT_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_rdy,
  input  logic              flush,
  output logic              cpt_en,
  output logic [WORD_W-1:0] iss_word,
  output logic [2:0]        iss_unit,
  output logic [2:0]        wb_en,
  output logic [3:0]        wb_addr,
  output logic              ill_err,
  output logic              busy
);

  localparam int LW = $clog2(MAX_LAT + 1);

  function automatic dec_t decode(input logic [WORD_W-1:0] w);
    dec_t d;
    d       = '0;
    d.dst   = w[DST_HI:DST_LO];
    d.src_a = w[SRCA_HI:SRCA_LO];
    d.src_b = w[SRCB_HI:SRCB_LO];
    case (unit_e'(w[UNIT_HI:UNIT_LO]))
      UNIT_ALU: begin
        d.oh = OH_ALU; d.wr = !w[CMP_BIT]; d.use_a = 1'b1; d.use_b = !w[MRF_BIT];
      end
      UNIT_MUL: begin
        d.oh = OH_MUL; d.wr = !w[MRF_BIT];
        d.use_a = |w[MSRC_HI:MSRC_LO]; d.use_b = |w[MSRC_HI:MSRC_LO];
      end
      UNIT_SHF: begin
        d.oh = OH_SHF; d.wr = 1'b1; d.use_a = 1'b1; d.use_b = !w[MRF_BIT];
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  dec_t             d;
  logic [LW-1:0]    lat;
  logic [NREG-1:0]  sb, sb_set, sb_clr;
  logic [MAX_LAT:0] occ;
  wb_ent_t          ret, rsv_ent;
  logic             haz, hs, iss, rsv;

  always_comb begin
    d = decode(in_word);
    lat = '0;
    if (d.oh == OH_ALU) lat = LW'(ALU_LAT);
    if (d.oh == OH_MUL) lat = LW'(MUL_LAT);
    if (d.oh == OH_SHF) lat = LW'(SHF_LAT);
  end

  // Illegal words bypass the hazard check entirely; flush blocks everything.
  assign haz    = (d.use_a && sb[d.src_a]) || (d.use_b && sb[d.src_b]) ||
                  (d.wr && (sb[d.dst] || occ[lat]));
  assign in_rdy = !flush && (d.ill || !haz);
  assign hs     = in_vld && in_rdy;
  assign iss    = hs && !d.ill;
  assign rsv    = iss && d.wr;

  assign rsv_ent = '{vld: 1'b1, unit: d.oh, addr: d.dst};
  assign sb_set  = rsv ? (NREG'(1) << d.dst) : '0;
  assign sb_clr  = ret.vld ? (NREG'(1) << ret.addr) : '0;

  cmpt_wb_slots #(.MAX_LAT(MAX_LAT)) u_slots (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .rsv     (rsv),
    .rsv_pos (lat - LW'(1)),
    .rsv_ent (rsv_ent),
    .occ     (occ),
    .ret     (ret)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cpt_en   <= 1'b0;
      iss_word <= '0;
      iss_unit <= '0;
      ill_err  <= 1'b0;
      sb       <= '0;
    end else begin
      cpt_en  <= iss;
      ill_err <= hs && d.ill;
      if (iss) begin
        iss_word <= in_word;
        iss_unit <= d.oh;
      end
      // A retiring register is freed at the end of its write-back cycle, no bypass.
      sb <= flush ? '0 : ((sb & ~sb_clr) | sb_set);
    end
  end

  assign wb_en   = {3{ret.vld}} & ret.unit;
  assign wb_addr = ret.addr;
  assign busy    = (|sb) || (|occ);

endmodule
